// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding,
// default sizing constants and the pass-length clamp helper.
package seq_tx_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_t;

  // Requested lengths beyond the pattern register are clamped to its width.
  function automatic int unsigned clampLen(input int unsigned len, input int unsigned patW);
    return (len > patW) ? patW : len;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Pattern storage and bit sequencing for seq_pattern_tx.
// Holds the captured pattern, the bit-index down-counter and the bit mux.
// o_next_bit is the bit that will be presented after this edge's
// load/advance, so the top can register it straight into dout.
// Build option SEQ_TX_PARITY_EN appends an even-parity bit to every pass.
module seq_tx_shreg
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_eff_len,
  input  logic             i_advance,
  output logic             o_next_bit,
  output logic             o_pass_end
);

  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_eff_len;
  logic [LEN_W-1:0] r_idx;

  logic [PAT_W-1:0] w_pattern_nxt;
  logic [LEN_W-1:0] w_idx_nxt;
  logic [LEN_W-1:0] w_reload_idx;
  logic [PAT_W-1:0] w_shifted;
  logic             w_last_data;

  assign w_reload_idx = r_eff_len - LEN_W'(1);
  assign w_last_data  = (r_idx == '0);

`ifdef SEQ_TX_PARITY_EN
  logic             r_par_phase;
  logic             r_parity;
  logic             w_par_phase_nxt;
  logic             w_parity_nxt;
  logic [PAT_W-1:0] w_mask;

  assign w_mask = (PAT_W'(1) << i_eff_len) - PAT_W'(1);

  // Next pattern/index/parity-phase given a load or a consumed bit.
  always_comb begin
    w_pattern_nxt   = r_pattern;
    w_idx_nxt       = r_idx;
    w_par_phase_nxt = r_par_phase;
    w_parity_nxt    = r_parity;
    if (i_load) begin
      w_pattern_nxt   = i_pattern;
      w_idx_nxt       = i_eff_len - LEN_W'(1);
      w_par_phase_nxt = 1'b0;
      w_parity_nxt    = ^(i_pattern & w_mask);
    end else if (i_advance) begin
      if (r_par_phase) begin
        w_par_phase_nxt = 1'b0;
        w_idx_nxt       = w_reload_idx;
      end else if (w_last_data) begin
        w_par_phase_nxt = 1'b1;
      end else begin
        w_idx_nxt = r_idx - LEN_W'(1);
      end
    end
  end

  assign w_shifted  = w_pattern_nxt >> w_idx_nxt;
  assign o_next_bit = w_par_phase_nxt ? w_parity_nxt : w_shifted[0];
  assign o_pass_end = r_par_phase;

  // Parity state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_phase <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      r_par_phase <= w_par_phase_nxt;
      r_parity    <= w_parity_nxt;
    end
  end
`else
  // Next pattern/index given a load or a consumed bit.
  always_comb begin
    w_pattern_nxt = r_pattern;
    w_idx_nxt     = r_idx;
    if (i_load) begin
      w_pattern_nxt = i_pattern;
      w_idx_nxt     = i_eff_len - LEN_W'(1);
    end else if (i_advance) begin
      if (w_last_data) begin
        w_idx_nxt = w_reload_idx;
      end else begin
        w_idx_nxt = r_idx - LEN_W'(1);
      end
    end
  end

  assign w_shifted  = w_pattern_nxt >> w_idx_nxt;
  assign o_next_bit = w_shifted[0];
  assign o_pass_end = w_last_data;
`endif

  // Pattern, window length and bit-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '0;
      r_eff_len <= '0;
      r_idx     <= '0;
    end else begin
      r_pattern <= w_pattern_nxt;
      r_idx     <= w_idx_nxt;
      if (i_load) begin
        r_eff_len <= i_eff_len;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts the low len bits of a captured
// pattern out MSB first, rpt+1 times back-to-back, with a valid/ready
// handshake and a one-cycle done pulse. All outputs are registered.
// Build option SEQ_TX_PARITY_EN adds an even-parity bit after each pass.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_rpt,
  input  logic             i_abort,
  input  logic             i_ready,
  output logic             o_dout,
  output logic             o_dout_valid,
  output logic             o_busy,
  output logic             o_done
);

  tx_state_t        r_state;
  logic [CNT_W:0]   r_passes;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_eff_len;
  logic             w_accept;
  logic             w_consume;
  logic             w_next_bit;
  logic             w_pass_end;

  assign w_eff_len = LEN_W'(clampLen(32'(i_len), PAT_W));
  assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_consume = (r_state == ST_SHIFT) && i_ready && !i_abort;

  seq_tx_shreg #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_pattern (i_pattern),
    .i_eff_len (w_eff_len),
    .i_advance (w_consume),
    .o_next_bit(w_next_bit),
    .o_pass_end(w_pass_end)
  );

  // Transfer FSM with pass counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_passes     <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          if (w_accept) begin
            r_passes <= {1'b0, i_rpt} + (CNT_W+1)'(1);
            r_busy   <= 1'b1;
            if (w_eff_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_SHIFT;
              r_dout_valid <= 1'b1;
              r_dout       <= w_next_bit;
            end
          end
        end
        ST_SHIFT: begin
          if (i_abort) begin
            r_state      <= ST_IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
          end else if (i_ready) begin
            if (w_pass_end && (r_passes == (CNT_W+1)'(1))) begin
              r_state      <= ST_DONE;
              r_dout       <= 1'b0;
              r_dout_valid <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              if (w_pass_end) begin
                r_passes <= r_passes - (CNT_W+1)'(1);
              end
              r_dout <= w_next_bit;
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
